// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection and a saturating count of inserted stall bubbles.
module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [31:0]       rf_data_1,
   input  logic [31:0]       rf_data_2,
   input  logic              exmem_reg_write,
   input  logic [4:0]        exmem_rd,
   input  logic [31:0]       exmem_result,
   input  logic              memwb_reg_write,
   input  logic [4:0]        memwb_rd,
   input  logic [31:0]       memwb_result,
   input  logic              flush,
   output logic              stall_out,
   output logic              ex_valid,
   output logic [31:0]       ex_op_a,
   output logic [31:0]       ex_op_b,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0] fwd_a;
   logic [31:0] fwd_b;
   logic        hz;

   // The youngest producer (EX/MEM) wins; r0 is never forwarded.
   function automatic logic [31:0] forward(
      input logic [4:0]  src,
      input logic [31:0] rf,
      input logic        em_we,
      input logic [4:0]  em_rd,
      input logic [31:0] em_res,
      input logic        mw_we,
      input logic [4:0]  mw_rd,
      input logic [31:0] mw_res
   );
      logic [31:0] sel;
      sel = rf;
      if (src != 5'd0) begin
         if (em_we && (em_rd == src))
            sel = em_res;
         else if (mw_we && (mw_rd == src))
            sel = mw_res;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a = forward(id_rs, rf_data_1, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
      fwd_b = forward(id_rt, rf_data_2, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
   end

   always_comb begin
      hz = ex_valid && ex_ctrl[1] && (ex_rd != 5'd0) && id_valid &&
           ((ex_rd == id_rs) || (ex_rd == id_rt));
      stall_out = hz && !flush;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ex_valid    <= 1'b0;
         ex_op_a     <= '0;
         ex_op_b     <= '0;
         ex_imm      <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= '0;
         stall_count <= '0;
      end else if (flush || stall_out) begin
         ex_valid <= 1'b0;
         ex_op_a  <= '0;
         ex_op_b  <= '0;
         ex_imm   <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
         ex_ctrl  <= '0;
         // Only load-use bubbles are counted, never flush bubbles.
         if (!flush && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_ONE;
      end else begin
         ex_valid <= id_valid;
         ex_op_a  <= fwd_a;
         ex_op_b  <= fwd_b;
         ex_imm   <= id_imm;
         ex_rs    <= id_rs;
         ex_rt    <= id_rt;
         ex_rd    <= id_rd;
         ex_ctrl  <= id_ctrl;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage, checked against a
// behavioural model of the ID/EX register, forwarding and stall rules.
module tb_id_ex_stage;

   logic        clock;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_imm;
   logic [7:0]  id_ctrl;
   logic [31:0] rf_data_1, rf_data_2;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        flush;

   logic        stall_out, ex_valid;
   logic [31:0] ex_op_a, ex_op_b, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [7:0]  ex_ctrl;
   logic [15:0] stall_count;

   logic        s4_stall_out, s4_ex_valid;
   logic [31:0] s4_ex_op_a, s4_ex_op_b, s4_ex_imm;
   logic [4:0]  s4_ex_rs, s4_ex_rt, s4_ex_rd;
   logic [7:0]  s4_ex_ctrl;
   logic [3:0]  s4_stall_count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   // Reference model state
   logic        m_valid;
   logic [31:0] m_a, m_b, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd;
   logic [7:0]  m_ctrl;
   int          m_cnt;
   logic        exp_stall, obs_stall;

   id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .flush(flush), .stall_out(stall_out), .ex_valid(ex_valid),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .stall_count(stall_count)
   );

   id_ex_stage #(.CTRL_W(8), .CNT_W(4)) dut4 (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .flush(flush), .stall_out(s4_stall_out), .ex_valid(s4_ex_valid),
      .ex_op_a(s4_ex_op_a), .ex_op_b(s4_ex_op_b), .ex_imm(s4_ex_imm),
      .ex_rs(s4_ex_rs), .ex_rt(s4_ex_rt), .ex_rd(s4_ex_rd), .ex_ctrl(s4_ex_ctrl),
      .stall_count(s4_stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] model_fwd(input logic [4:0] src, input logic [31:0] rf);
      if (src == 5'd0) return rf;
      if (exmem_reg_write && exmem_rd == src) return exmem_result;
      if (memwb_reg_write && memwb_rd == src) return memwb_result;
      return rf;
   endfunction

   function automatic logic model_hz();
      return m_valid && m_ctrl[1] && m_rd != 5'd0 && id_valid &&
             (m_rd == id_rs || m_rd == id_rt);
   endfunction

   function automatic logic [119:0] model_bundle();
      return {m_valid, m_a, m_b, m_imm, m_rs, m_rt, m_rd, m_ctrl};
   endfunction

   function automatic logic [119:0] dut_bundle();
      return {ex_valid, ex_op_a, ex_op_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl};
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Settle, sample stall_out before the edge, clock once, advance the model.
   task automatic tick();
      logic stall_now;
      #1;
      obs_stall = stall_out;
      exp_stall = model_hz() && !flush;
      stall_now = exp_stall;
      @(posedge clock);
      #1;
      if (!reset) begin
         {m_valid, m_a, m_b, m_imm, m_rs, m_rt, m_rd, m_ctrl} = '0;
         m_cnt = 0;
      end else if (flush || stall_now) begin
         {m_valid, m_a, m_b, m_imm, m_rs, m_rt, m_rd, m_ctrl} = '0;
         if (!flush) m_cnt++;
      end else begin
         m_valid = id_valid;
         m_a = model_fwd(id_rs, rf_data_1);
         m_b = model_fwd(id_rt, rf_data_2);
         m_imm = id_imm; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_ctrl = id_ctrl;
      end
      n_txn++;
      $display("txn %0d: rst=%b flush=%b stall=%b ex_valid=%b rd=%0d op_a=%h op_b=%h cnt=%0d",
               n_txn, reset, flush, obs_stall, ex_valid, ex_rd, ex_op_a, ex_op_b, stall_count);
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [7:0] ctrl);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
      id_imm = $urandom; rf_data_1 = $urandom; rf_data_2 = $urandom;
   endtask

   task automatic quiet_wb();
      exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
      exmem_rd = '0; memwb_rd = '0; exmem_result = '0; memwb_result = '0;
      flush = 1'b0;
   endtask

   task automatic randomize_inputs(input int flush_pct);
      set_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 8'($urandom));
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7));
      memwb_result = $urandom;
      flush = ($urandom_range(0, 99) < flush_pct);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) begin
         randomize_inputs(30);
         tick();
      end
      n_checks++;
      if (dut_bundle() !== 120'd0) begin
         n_fail++; $display("FAIL reset_ex: got %h want 0", dut_bundle());
      end
      n_checks++;
      if (stall_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out);
      end
      n_checks++;
      if (stall_count !== 16'd0 || s4_stall_count !== 4'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d/%0d want 0", stall_count, s4_stall_count);
      end
   endtask

   task automatic test_forward_priority();
      reset = 1'b1;
      quiet_wb();
      set_id(1'b1, 5'd5, 5'd9, 5'd0, 8'h00);
      rf_data_1 = 32'h1;
      exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA0000;
      memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h5555;
      tick();
      n_checks++;
      if (ex_op_a !== 32'hAAAA0000) begin
         n_fail++; $display("FAIL fwd_exmem: got %h want aaaa0000", ex_op_a);
      end
      exmem_reg_write = 1'b0;
      tick();
      n_checks++;
      if (ex_op_a !== 32'h5555) begin
         n_fail++; $display("FAIL fwd_memwb: got %h want 00005555", ex_op_a);
      end
      memwb_reg_write = 1'b0;
      tick();
      n_checks++;
      if (ex_op_a !== rf_data_1) begin
         n_fail++; $display("FAIL fwd_rf: got %h want %h", ex_op_a, rf_data_1);
      end
   endtask

   task automatic test_r0_guard();
      quiet_wb();
      set_id(1'b1, 5'd7, 5'd0, 5'd0, 8'h00);
      rf_data_2 = 32'h0;
      exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
      memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
      tick();
      n_checks++;
      if (ex_op_b !== 32'h0) begin
         n_fail++; $display("FAIL r0_guard: got %h want 0", ex_op_b);
      end
   endtask

   task automatic test_load_use();
      int cnt0;
      quiet_wb();
      cnt0 = m_cnt;
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 8'h03);
      tick();
      set_id(1'b1, 5'd3, 5'd4, 5'd6, 8'h01);
      tick();
      n_checks++;
      if (obs_stall !== 1'b1) begin
         n_fail++; $display("FAIL loaduse_stall: got %b want 1", obs_stall);
      end
      n_checks++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
         n_fail++; $display("FAIL loaduse_bubble: got valid=%b ctrl=%h want 0/00", ex_valid, ex_ctrl);
      end
      n_checks++;
      if (stall_count !== 16'(cnt0 + 1)) begin
         n_fail++; $display("FAIL loaduse_count: got %0d want %0d", stall_count, cnt0 + 1);
      end
      tick();
      n_checks++;
      if (obs_stall !== 1'b0) begin
         n_fail++; $display("FAIL loaduse_release: got %b want 0", obs_stall);
      end
      n_checks++;
      if (ex_valid !== 1'b1 || ex_rs !== 5'd3 || ex_rd !== 5'd6) begin
         n_fail++; $display("FAIL loaduse_reload: got v=%b rs=%0d rd=%0d want 1/3/6",
                            ex_valid, ex_rs, ex_rd);
      end
   endtask

   task automatic test_flush_vs_hazard();
      int cnt0;
      quiet_wb();
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 8'h03);
      tick();
      cnt0 = m_cnt;
      set_id(1'b1, 5'd3, 5'd3, 5'd8, 8'h01);
      flush = 1'b1;
      tick();
      n_checks++;
      if (obs_stall !== 1'b0) begin
         n_fail++; $display("FAIL flush_stall: got %b want 0", obs_stall);
      end
      n_checks++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
         n_fail++; $display("FAIL flush_bubble: got valid=%b ctrl=%h want 0/00", ex_valid, ex_ctrl);
      end
      n_checks++;
      if (stall_count !== 16'(cnt0)) begin
         n_fail++; $display("FAIL flush_count: got %0d want %0d", stall_count, cnt0);
      end
      flush = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         randomize_inputs(10);
         reset = ($urandom_range(0, 59) != 0);
         tick();
         n_checks++;
         if (obs_stall !== exp_stall) begin
            n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", i, obs_stall, exp_stall);
         end
         n_checks++;
         if (dut_bundle() !== model_bundle()) begin
            n_fail++; $display("FAIL rand_ex[%0d]: got %h want %h", i, dut_bundle(), model_bundle());
         end
         n_checks++;
         if (stall_count !== 16'(sat(m_cnt, 65535)) || s4_stall_count !== 4'(sat(m_cnt, 15))) begin
            n_fail++; $display("FAIL rand_count[%0d]: got %0d/%0d want %0d/%0d", i, stall_count,
                               s4_stall_count, sat(m_cnt, 65535), sat(m_cnt, 15));
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_saturation();
      int stalls;
      stalls = 0;
      quiet_wb();
      reset = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_id(1'b1, 5'd1, 5'd2, 5'd3, 8'h03);
         tick();
         set_id(1'b1, 5'd3, 5'd4, 5'd5, 8'h01);
         tick();
         if (obs_stall === 1'b1) stalls++;
      end
      n_checks++;
      if (stalls != 17) begin
         n_fail++; $display("FAIL sat_stalls: got %0d want 17", stalls);
      end
      n_checks++;
      if (s4_stall_count !== 4'd15) begin
         n_fail++; $display("FAIL sat_count4: got %0d want 15", s4_stall_count);
      end
      n_checks++;
      if (stall_count !== 16'd17) begin
         n_fail++; $display("FAIL sat_count16: got %0d want 17", stall_count);
      end
   endtask

   initial begin
      {m_valid, m_a, m_b, m_imm, m_rs, m_rt, m_rd, m_ctrl} = '0;
      m_cnt = 0;
      reset = 1'b0;
      quiet_wb();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00);
      test_reset();
      test_forward_priority();
      test_r0_guard();
      test_load_use();
      test_flush_vs_hazard();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
